// File: rtl/csi_rx_pkt_engine.sv
// CSI-2 receive packet engine.
// Sits behind the byte/word aligner: collects the 4-byte packet header over
// 4/LANES aligned words, checks ECC and data type, then streams long-packet
// payload out one registered word per accepted input word. It tracks frame and
// line status from FS/FE and image packets, and counts bad headers with a
// saturating counter.
//
// Ports
//   clock, reset        clock; asynchronous active-high reset
//   enable              clock enable (registers hold when low, pulses clear)
//   data, data_valid    aligned input word, byte 0 in data[7:0]
//   sync_wait           aligner wait_for_sync (engine is idle, hunting a header)
//   packet_done         aligner packet_done (one cycle per packet)
//   payload_*           payload stream; keep bit i = byte i valid
//   vc_out, dt_out      virtual channel / data type of the latest header
//   frame_start/end     single-cycle pulses on forwarded FS / FE
//   in_frame, in_line   frame and line status
//   err_count           saturating count of rejected headers

// Header ECC: 6-bit Hamming parity over {B2, B1, B0}, top two bits zero.
module csi_rx_hdr_ecc (
  input  logic [23:0] data,
  output logic [7:0]  ecc
);
  // Each mask selects the data bits covered by one parity bit.
  localparam logic [23:0] P0 = 24'hF12CB7;
  localparam logic [23:0] P1 = 24'hF2555B;
  localparam logic [23:0] P2 = 24'h749A6D;
  localparam logic [23:0] P3 = 24'hB8E38E;
  localparam logic [23:0] P4 = 24'hDF03F0;
  localparam logic [23:0] P5 = 24'hEFFC00;

  assign ecc = {2'b00, ^(data & P5), ^(data & P4), ^(data & P3),
                ^(data & P2), ^(data & P1), ^(data & P0)};
endmodule

// One payload byte lane: registers the byte and its keep flag on load.
// keep drops on any enabled cycle without a load, so it never outlives
// the valid word it belongs to.
module csi_rx_pkt_lane (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic [7:0] byte_in,
  input  logic       keep_in,
  output logic [7:0] byte_out,
  output logic       keep_out
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_out <= '0;
      keep_out <= 1'b0;
    end else if (enable) begin
      if (load) begin
        byte_out <= byte_in;
        keep_out <= keep_in;
      end else begin
        keep_out <= 1'b0;
      end
    end
  end
endmodule

module csi_rx_pkt_engine #(
  parameter int          LANES     = 2,
  parameter logic [3:0]  VC_MASK   = 4'b0001,
  parameter int          MAX_LEN   = 8192,
  // Value at which err_count sticks.
  parameter logic [15:0] ERR_LIMIT = 16'hFFFF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [8*LANES-1:0]   data,
  input  logic                 data_valid,
  output logic                 sync_wait,
  output logic                 packet_done,
  output logic [8*LANES-1:0]   payload_out,
  output logic [LANES-1:0]     payload_keep,
  output logic                 payload_valid,
  output logic                 payload_last,
  output logic [1:0]           vc_out,
  output logic [5:0]           dt_out,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic                 in_frame,
  output logic                 in_line,
  output logic [15:0]          err_count
);
  localparam int HDR_WORDS = 4 / LANES;

  typedef enum logic [2:0] {INIT, WAIT_SYNC, HDR, PAYLOAD, DONE, GAP} state_t;

  // Header as it sits on the wire, {B3, B2, B1, B0}.
  typedef struct packed {
    logic [7:0]  ecc;
    logic [15:0] wc;
    logic [1:0]  vc;
    logic [5:0]  dt;
  } hdr_t;

  state_t                  state, state_n;
  logic [LANES-1:0][7:0]   data_b;
  logic [3:0][7:0]         hdr_buf, hdr_cur;
  logic [1:0]              hdr_idx, word_idx;
  hdr_t                    hdr;
  logic [7:0]              ecc_calc;
  logic [15:0]             bytes_rem;
  logic                    hdr_acc, hdr_last, hdr_ok, fwd;
  logic                    dt_short, dt_long, dt_image;
  logic                    pay_acc, pay_load, pay_final;

  assign data_b      = data;
  assign sync_wait   = (state == WAIT_SYNC);
  assign packet_done = (state == DONE);

  // Header assembly: merge the word being accepted into the buffered bytes so
  // the whole header can be decoded on the cycle its last word arrives.
  assign word_idx = (state == HDR) ? hdr_idx : 2'd0;
  assign hdr_acc  = enable && data_valid && (state == WAIT_SYNC || state == HDR);
  assign hdr_last = hdr_acc && (word_idx == 2'(HDR_WORDS - 1));

  always_comb begin
    hdr_cur = hdr_buf;
    for (int i = 0; i < LANES; i++)
      hdr_cur[2'(int'(word_idx) * LANES + i)] = data_b[i];
  end

  assign hdr = hdr_t'(hdr_cur);

  csi_rx_hdr_ecc u_ecc (
    .data (hdr_cur[2:0]),
    .ecc  (ecc_calc)
  );

  assign dt_short = (hdr.dt <= 6'h07);
  assign dt_long  = (hdr.dt >= 6'h10) && (hdr.dt <= 6'h2F);
  assign dt_image = (hdr.dt >= 6'h18) && (hdr.dt <= 6'h2F);
  assign hdr_ok   = (hdr.ecc == ecc_calc) && (dt_short || dt_long) &&
                    !(dt_long && ({16'd0, hdr.wc} > 32'(MAX_LEN)));
  assign fwd      = VC_MASK[hdr.vc];

  // Payload: vc_out is already latched for the current packet, so it decides
  // forwarding for every payload word.
  assign pay_acc   = enable && data_valid && (state == PAYLOAD);
  assign pay_final = (bytes_rem <= 16'(LANES));
  assign pay_load  = pay_acc && VC_MASK[vc_out];

  always_comb begin
    state_n = state;
    case (state)
      INIT:      state_n = WAIT_SYNC;
      WAIT_SYNC,
      HDR: begin
        if (hdr_last)
          state_n = (!hdr_ok || !dt_long || hdr.wc == 16'd0) ? DONE : PAYLOAD;
        else if (hdr_acc)
          state_n = HDR;
      end
      PAYLOAD:   if (pay_acc && pay_final) state_n = DONE;
      DONE:      state_n = GAP;
      GAP:       state_n = WAIT_SYNC;
      default:   state_n = INIT;
    endcase
  end

  genvar g;
  for (g = 0; g < LANES; g++) begin : g_lane
    csi_rx_pkt_lane u_lane (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .load     (pay_load),
      .byte_in  (data_b[g]),
      .keep_in  (bytes_rem > 16'(g)),
      .byte_out (payload_out[8*g +: 8]),
      .keep_out (payload_keep[g])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= INIT;
      hdr_buf       <= '0;
      hdr_idx       <= 2'd0;
      bytes_rem     <= 16'd0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      vc_out        <= 2'd0;
      dt_out        <= 6'd0;
      frame_start   <= 1'b0;
      frame_end     <= 1'b0;
      in_frame      <= 1'b0;
      in_line       <= 1'b0;
      err_count     <= 16'd0;
    end else begin
      // Pulses and the payload qualifier drop on every cycle, enabled or not.
      frame_start   <= 1'b0;
      frame_end     <= 1'b0;
      payload_valid <= 1'b0;
      if (enable) begin
        state         <= state_n;
        payload_valid <= pay_load;
        payload_last  <= pay_load && pay_final;

        if (hdr_acc) begin
          hdr_buf <= hdr_cur;
          hdr_idx <= hdr_last ? 2'd0 : 2'(word_idx + 2'd1);
        end

        // A line that never saw payload_last (WC = 0, or an error) ends here.
        if (state == WAIT_SYNC) in_line <= 1'b0;

        if (hdr_last) begin
          vc_out <= hdr.vc;
          dt_out <= hdr.dt;
          if (!hdr_ok) begin
            if (err_count < ERR_LIMIT) err_count <= err_count + 16'd1;
          end else begin
            bytes_rem <= dt_long ? hdr.wc : 16'd0;
            if (fwd) begin
              if (hdr.dt == 6'h00) begin
                in_frame    <= 1'b1;
                frame_start <= 1'b1;
              end
              if (hdr.dt == 6'h01 && in_frame) begin
                in_frame  <= 1'b0;
                frame_end <= 1'b1;
              end
              if (dt_image) in_line <= 1'b1;
            end
          end
        end

        if (pay_acc) begin
          bytes_rem <= pay_final ? 16'd0 : bytes_rem - 16'(LANES);
          if (pay_load && pay_final) in_line <= 1'b0;
        end
      end
    end
  end
endmodule
